// File: rtl/cmul_seq_arbiter.sv
// cmul_seq_arbiter: round-robin arbiter sharing one 2W-bit multiplier across
// N_REQ requesters. Each operation is a 4-step complex multiply that produces
// {re, im}.
// Optional macro CMUL_SIGNED_EN: operand components are treated as
// two's-complement signed and sign-extended before the multiply.
module cmul_seq_arbiter #(
  parameter int W     = 8,
  parameter int N_REQ = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*2*W-1:0]         op1_bus,
  input  logic [N_REQ*2*W-1:0]         op2_bus,
  output logic [N_REQ-1:0]             gnt,
  output logic                         busy,
  output logic                         out_valid,
  output logic [$clog2(N_REQ)-1:0]     out_id,
  output logic [4*W-1:0]               product
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = 2 * W;

  typedef enum logic [2:0] {IDLE, MUL_AC, MUL_BD, MUL_AD, MUL_BC, DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   last, cur_id, sel_id, cand;
  logic            any_req;
  logic [W-1:0]    a, b, c, d;
  logic [CW-1:0]   op1_arr [N_REQ];
  logic [CW-1:0]   op2_arr [N_REQ];
  logic [CW-1:0]   mul_x, mul_y, mul_res;
  logic [CW-1:0]   acc_re, acc_im;
  int unsigned     idx;

  // Widen one W-bit operand component to the 2W-bit arithmetic width.
  function automatic logic [CW-1:0] ext(input logic [W-1:0] v);
`ifdef CMUL_SIGNED_EN
    return {{W{v[W-1]}}, v};
`else
    return {{W{1'b0}}, v};
`endif
  endfunction

  // Split the flat operand buses into per-requester words.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      op1_arr[i] = op1_bus[i*CW +: CW];
      op2_arr[i] = op2_bus[i*CW +: CW];
    end
  end

  // Round-robin pick: first active request at or after last+1 (mod N_REQ).
  always_comb begin
    any_req = 1'b0;
    sel_id  = '0;
    idx     = 0;
    cand    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx  = (32'(last) + k) % N_REQ;
      cand = IW'(idx);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        sel_id  = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: fixed four-step sequence once granted.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = MUL_AC;
      MUL_AC:  state_nxt = MUL_BD;
      MUL_BD:  state_nxt = MUL_AD;
      MUL_AD:  state_nxt = MUL_BC;
      MUL_BC:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Steer the latched operand pair named by the current step into the multiplier.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    unique case (state)
      MUL_AC:  begin mul_x = ext(a); mul_y = ext(c); end
      MUL_BD:  begin mul_x = ext(b); mul_y = ext(d); end
      MUL_AD:  begin mul_x = ext(a); mul_y = ext(d); end
      MUL_BC:  begin mul_x = ext(b); mul_y = ext(c); end
      default: begin mul_x = '0;     mul_y = '0;     end
    endcase
  end

  assign mul_res = mul_x * mul_y;

  // Operand capture at the grant edge, accumulation, and result registration.
  always_ff @(posedge clk) begin
    if (rst) begin
      last    <= IW'(N_REQ - 1);
      cur_id  <= '0;
      a       <= '0;
      b       <= '0;
      c       <= '0;
      d       <= '0;
      acc_re  <= '0;
      acc_im  <= '0;
      product <= '0;
      out_id  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            last   <= sel_id;
            cur_id <= sel_id;
            a      <= op1_arr[sel_id][CW-1:W];
            b      <= op1_arr[sel_id][W-1:0];
            c      <= op2_arr[sel_id][CW-1:W];
            d      <= op2_arr[sel_id][W-1:0];
          end
        end
        MUL_AC: acc_re <= mul_res;
        MUL_BD: acc_re <= acc_re - mul_res;
        MUL_AD: acc_im <= mul_res;
        MUL_BC: begin
          acc_im  <= acc_im + mul_res;
          product <= {acc_re, acc_im + mul_res};
          out_id  <= cur_id;
        end
        default: ;
      endcase
    end
  end

  // Status outputs decoded from state; the grant follows the owner until DONE ends.
  always_comb begin
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    gnt       = '0;
    if (state != IDLE) gnt[cur_id] = 1'b1;
  end

endmodule

// File: tb/tb_cmul_seq_arbiter.sv
// Self-checking bench for cmul_seq_arbiter with W=8, N_REQ=2.
module tb_cmul_seq_arbiter;

  localparam int W     = 8;
  localparam int N_REQ = 2;
  localparam int IW    = $clog2(N_REQ);
  localparam int CW    = 2 * W;

  logic                     clk;
  logic                     rst;
  logic [N_REQ-1:0]         req;
  logic [N_REQ*CW-1:0]      op1_bus;
  logic [N_REQ*CW-1:0]      op2_bus;
  logic [N_REQ-1:0]         gnt;
  logic                     busy;
  logic                     out_valid;
  logic [IW-1:0]            out_id;
  logic [4*W-1:0]           product;

  int checks = 0;
  int errors = 0;

  cmul_seq_arbiter #(.W(W), .N_REQ(N_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op1_bus   (op1_bus),
    .op2_bus   (op2_bus),
    .gnt       (gnt),
    .busy      (busy),
    .out_valid (out_valid),
    .out_id    (out_id),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference complex product computed with plain integer arithmetic.
  function automatic logic [4*W-1:0] cmul_model(input logic [CW-1:0] o1, input logic [CW-1:0] o2);
    int ra, rb, rc, rd, re, im;
    logic [31:0] re_v, im_v;
`ifdef CMUL_SIGNED_EN
    ra = $signed(o1[CW-1:W]); rb = $signed(o1[W-1:0]);
    rc = $signed(o2[CW-1:W]); rd = $signed(o2[W-1:0]);
`else
    ra = int'(o1[CW-1:W]); rb = int'(o1[W-1:0]);
    rc = int'(o2[CW-1:W]); rd = int'(o2[W-1:0]);
`endif
    re = ra * rc - rb * rd;
    im = ra * rd + rb * rc;
    re_v = re;
    im_v = im;
    return {re_v[CW-1:0], im_v[CW-1:0]};
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input int id);
    logic [N_REQ-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Issue one request from an idle DUT, observe until out_valid (bounded), then release.
  task automatic do_op(input int id, input logic [CW-1:0] o1, input logic [CW-1:0] o2,
                       output logic [4*W-1:0] prod, output logic [IW-1:0] oid,
                       output int lat, output int gnt_bad);
    op1_bus[id*CW +: CW] = o1;
    op2_bus[id*CW +: CW] = o2;
    req = onehot(id);
    lat = 0;
    gnt_bad = 0;
    do begin
      @(negedge clk);
      lat++;
      if (gnt !== onehot(id)) gnt_bad++;
    end while (out_valid !== 1'b1 && lat < 20);
    prod = product;
    oid  = out_id;
    req  = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; op1_bus = '0; op2_bus = '0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (gnt !== '0)        begin errors++; $display("FAIL reset_gnt got %b exp 0", gnt); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    if (out_id !== '0)     begin errors++; $display("FAIL reset_out_id got %0d exp 0", out_id); end
    if (product !== '0)    begin errors++; $display("FAIL reset_product got %h exp 0", product); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [4*W-1:0] p; logic [IW-1:0] oid; int lat, gb;
    do_op(0, 16'h0202, 16'h0602, p, oid, lat, gb);
    checks += 8;
    if (p !== 32'h00080010) begin errors++; $display("FAIL basic_product got %h exp 00080010", p); end
    if (oid !== 1'b0)       begin errors++; $display("FAIL basic_out_id got %0d exp 0", oid); end
    if (lat !== 5)          begin errors++; $display("FAIL basic_latency got %0d exp 5", lat); end
    if (gb !== 0)           begin errors++; $display("FAIL basic_gnt_hold got %0d bad cycles exp 0", gb); end
    if (gnt !== '0)         begin errors++; $display("FAIL basic_gnt_after got %b exp 0", gnt); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL basic_busy_after got %b exp 0", busy); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %b exp 0", out_valid); end
    if (product !== 32'h00080010) begin errors++; $display("FAIL basic_product_hold got %h exp 00080010", product); end
  endtask

  task automatic test_wrap();
    logic [4*W-1:0] p, e1, e2; logic [IW-1:0] oid; int lat, gb;
`ifdef CMUL_SIGNED_EN
    e1 = 32'h00000002; e2 = 32'hFE82FEFD;
`else
    e1 = 32'h0000FC02; e2 = 32'hFF8203FD;
`endif
    do_op(1, 16'hFFFF, 16'hFFFF, p, oid, lat, gb);
    checks += 2;
    if (p !== e1)     begin errors++; $display("FAIL wrap_ffff got %h exp %h", p, e1); end
    if (oid !== 1'b1) begin errors++; $display("FAIL wrap_out_id got %0d exp 1", oid); end
    do_op(0, 16'h80FF, 16'h0302, p, oid, lat, gb);
    checks += 1;
    if (p !== e2)     begin errors++; $display("FAIL wrap_80ff got %h exp %h", p, e2); end
  endtask

  task automatic test_random();
    logic [4*W-1:0] p, e; logic [IW-1:0] oid; int lat, gb, id;
    logic [CW-1:0] o1, o2;
    for (int n = 0; n < 16; n++) begin
      op1_bus = (N_REQ*CW)'($urandom);
      op2_bus = (N_REQ*CW)'($urandom);
      id = int'($urandom_range(0, N_REQ - 1));
      o1 = CW'($urandom);
      o2 = CW'($urandom);
      e  = cmul_model(o1, o2);
      do_op(id, o1, o2, p, oid, lat, gb);
      checks += 4;
      if (p !== e)        begin errors++; $display("FAIL rand_product[%0d] got %h exp %h", n, p, e); end
      if (oid !== IW'(id)) begin errors++; $display("FAIL rand_out_id[%0d] got %0d exp %0d", n, oid, id); end
      if (lat !== 5)      begin errors++; $display("FAIL rand_latency[%0d] got %0d exp 5", n, lat); end
      if (gb !== 0)       begin errors++; $display("FAIL rand_gnt_hold[%0d] got %0d bad cycles exp 0", n, gb); end
    end
  endtask

  task automatic test_round_robin();
    logic [CW-1:0] o1 [N_REQ];
    logic [CW-1:0] o2 [N_REQ];
    int exp_id [3];
    int ptr, j, ph;
    logic exp_busy, exp_ov;
    logic [N_REQ-1:0] exp_gnt;
    rst = 1'b1; req = '0;
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) begin
      o1[i] = CW'($urandom); o2[i] = CW'($urandom) ^ CW'(i + 1);
      op1_bus[i*CW +: CW] = o1[i];
      op2_bus[i*CW +: CW] = o2[i];
    end
    ptr = N_REQ - 1;
    for (int i = 0; i < 3; i++) begin
      ptr = (ptr + 1) % N_REQ;
      exp_id[i] = ptr;
    end
    req = '1;
    rst = 1'b0;
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      j = k / 6; ph = k % 6;
      exp_busy = (ph != 5);
      exp_ov   = (ph == 4);
      exp_gnt  = (ph != 5) ? onehot(exp_id[j]) : '0;
      checks += 3;
      if (busy !== exp_busy)     begin errors++; $display("FAIL rr_busy[%0d] got %b exp %b", k, busy, exp_busy); end
      if (out_valid !== exp_ov)  begin errors++; $display("FAIL rr_out_valid[%0d] got %b exp %b", k, out_valid, exp_ov); end
      if (gnt !== exp_gnt)       begin errors++; $display("FAIL rr_gnt[%0d] got %b exp %b", k, gnt, exp_gnt); end
      if (exp_ov) begin
        checks += 2;
        if (out_id !== IW'(exp_id[j])) begin errors++; $display("FAIL rr_out_id[%0d] got %0d exp %0d", k, out_id, exp_id[j]); end
        if (product !== cmul_model(o1[exp_id[j]], o2[exp_id[j]])) begin
          errors++; $display("FAIL rr_product[%0d] got %h exp %h", k, product, cmul_model(o1[exp_id[j]], o2[exp_id[j]]));
        end
      end
      if (k == 16) req = '0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    logic [4*W-1:0] p, e; logic [IW-1:0] oid; int lat, gb, pulses;
    logic [CW-1:0] o1, o2;
    o1 = 16'h1234; o2 = 16'h5678;
    op1_bus[CW +: CW] = o1; op2_bus[CW +: CW] = o2;
    req = onehot(1);
    repeat (3) @(negedge clk);
    checks += 1;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b exp 1", busy); end
    rst = 1'b1; req = '0;
    @(negedge clk);
    checks += 5;
    if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    if (gnt !== '0)         begin errors++; $display("FAIL midrst_gnt got %b exp 0", gnt); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", out_valid); end
    if (product !== '0)     begin errors++; $display("FAIL midrst_product got %h exp 0", product); end
    if (out_id !== '0)      begin errors++; $display("FAIL midrst_out_id got %0d exp 0", out_id); end
    rst = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulses++;
    end
    checks += 1;
    if (pulses !== 0) begin errors++; $display("FAIL midrst_aborted_pulse got %0d exp 0", pulses); end
    e = cmul_model(o1, o2);
    do_op(1, o1, o2, p, oid, lat, gb);
    checks += 3;
    if (p !== e)      begin errors++; $display("FAIL midrst_retry_product got %h exp %h", p, e); end
    if (oid !== 1'b1) begin errors++; $display("FAIL midrst_retry_out_id got %0d exp 1", oid); end
    if (lat !== 5)    begin errors++; $display("FAIL midrst_retry_latency got %0d exp 5", lat); end
  endtask

  task automatic test_operand_stability();
    logic [CW-1:0] o1, o2;
    logic [4*W-1:0] e;
    int lat;
    for (int n = 0; n < 4; n++) begin
      o1 = CW'($urandom); o2 = CW'($urandom);
      e  = cmul_model(o1, o2);
      op1_bus[0 +: CW] = o1; op2_bus[0 +: CW] = o2;
      req = onehot(0);
      @(negedge clk);
      op1_bus[0 +: CW] = ~o1;
      op2_bus[0 +: CW] = o2 ^ 16'h5A5A;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      checks += 2;
      if (lat !== 5)    begin errors++; $display("FAIL stable_latency[%0d] got %0d exp 5", n, lat); end
      if (product !== e) begin errors++; $display("FAIL stable_product[%0d] got %h exp %h", n, product, e); end
      req = '0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_random();
    test_round_robin();
    test_reset_mid_op();
    test_operand_stability();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
